// File: rtl/md_stall_ctrl.sv
// md_stall_ctrl: multiply/divide busy sequencer with pipeline stall, enable and bubble controls.
module md_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start_E,
  input  logic [1:0]  md_op_E,
  input  logic        md_use_D,
  input  logic        load_use_D,
  input  logic        exc_flush,
  output logic        busy,
  output logic [1:0]  md_kind,
  output logic        md_done,
  output logic        stall,
  output logic        PC_EN,
  output logic        IFID_EN,
  output logic        NOP_CLR,
  output logic [31:0] stall_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);
  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]  kind_q, kind_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        accept;
  assign busy      = state_q == RUN;
  assign md_done   = state_q == DONE;
  assign md_kind   = kind_q;
  assign stall_cnt = stall_cnt_q;
  assign stall     = (md_use_D & (start_E | busy)) | load_use_D;
  assign PC_EN     = ~stall;
  assign IFID_EN   = ~stall;
  assign NOP_CLR   = stall | exc_flush;
  // A start coincident with an M-stage exception belongs to a killed instruction.
  assign accept    = start_E & ~exc_flush & ~busy;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kind_d      = kind_q;
    stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    if (busy) begin
      state_d = (cnt_q == '0) ? DONE : RUN;
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    end else if (accept) begin
      state_d = RUN;
      cnt_d   = md_op_E[1] ? DIV_LD : MULT_LD;
      kind_d  = md_op_E;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      kind_q      <= 2'b00;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kind_q      <= kind_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_md_stall_ctrl.sv
// tb_md_stall_ctrl: vector table, directed corner sequences and random run against a cycle-count model.
module tb_md_stall_ctrl;
  localparam int MULT = 5;
  localparam int DIV  = 10;
  logic        CLK = 0;
  logic        reset = 0;
  logic        start_E = 0;
  logic [1:0]  md_op_E = 0;
  logic        md_use_D = 0;
  logic        load_use_D = 0;
  logic        exc_flush = 0;
  logic        busy, md_done, stall, PC_EN, IFID_EN, NOP_CLR;
  logic [1:0]  md_kind;
  logic [31:0] stall_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int rem = 0;
  bit mdone = 0;
  logic [1:0] mkind = 0;
  longint mcnt = 0;
  md_stall_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_W(4)) dut (
    .CLK(CLK), .reset(reset), .start_E(start_E), .md_op_E(md_op_E), .md_use_D(md_use_D),
    .load_use_D(load_use_D), .exc_flush(exc_flush), .busy(busy), .md_kind(md_kind),
    .md_done(md_done), .stall(stall), .PC_EN(PC_EN), .IFID_EN(IFID_EN), .NOP_CLR(NOP_CLR),
    .stall_cnt(stall_cnt)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic start, use_d, lu, exc, e_stall, e_nop;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit m_stall();
    return (md_use_D && (start_E || rem > 0)) || load_use_D;
  endfunction
  task automatic m_reset();
    rem = 0; mdone = 0; mkind = 0; mcnt = 0;
  endtask
  task automatic cmp_all();
    @(negedge CLK);
    chk("busy", 32'(busy), 32'(rem > 0));
    chk("md_done", 32'(md_done), 32'(mdone));
    chk("md_kind", 32'(md_kind), 32'(mkind));
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("PC_EN", 32'(PC_EN), 32'(!m_stall()));
    chk("IFID_EN", 32'(IFID_EN), 32'(!m_stall()));
    chk("NOP_CLR", 32'(NOP_CLR), 32'(m_stall() || exc_flush));
    chk("stall_cnt", stall_cnt, 32'(mcnt));
  endtask
  // Model: rem counts busy cycles still owed; done follows the last busy cycle.
  task automatic tick();
    bit acc;
    @(posedge CLK);
    if (reset) begin
      acc = start_E && !exc_flush && rem == 0;
      if (m_stall()) mcnt = (mcnt < 64'hFFFF_FFFF) ? mcnt + 1 : mcnt;
      mdone = (rem == 1);
      rem = rem > 0 ? rem - 1 : (acc ? (md_op_E[1] ? DIV : MULT) : 0);
      if (acc) mkind = md_op_E;
    end
    #1;
  endtask
  task automatic cyc();
    cmp_all();
    tick();
  endtask
  task automatic do_reset();
    reset = 0;
    #2;
    m_reset();
    reset = 1;
  endtask
  task automatic idle_inputs();
    start_E = 0; md_op_E = 0; md_use_D = 0; load_use_D = 0; exc_flush = 0;
  endtask
  initial begin
    int busy_n, done_at, stall_n, done2_at;
    logic [6:0] bmask, dmask;
    vecs[0] = '{0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 0, 0, 0};
    vecs[2] = '{1, 1, 0, 0, 1, 1};
    vecs[3] = '{0, 0, 1, 0, 1, 1};
    vecs[4] = '{0, 0, 0, 1, 0, 1};
    vecs[5] = '{1, 0, 0, 1, 0, 1};
    vecs[6] = '{1, 1, 0, 1, 1, 1};
    vecs[7] = '{1, 0, 0, 0, 0, 0};
    // Reset held low: state frozen idle, so outputs are purely combinational.
    for (int i = 0; i < 8; i++) begin
      start_E = vecs[i].start; md_use_D = vecs[i].use_d;
      load_use_D = vecs[i].lu; exc_flush = vecs[i].exc;
      #1;
      chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d.pc_en", i), 32'(PC_EN), 32'(!vecs[i].e_stall));
      chk($sformatf("vec%0d.nop", i), 32'(NOP_CLR), 32'(vecs[i].e_nop));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'd0);
    end
    idle_inputs();
    @(posedge CLK); #1;
    do_reset();
    @(negedge CLK);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(md_done), 0);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.pc_en", 32'(PC_EN), 1);
    chk("rst.nop", 32'(NOP_CLR), 0);
    chk("rst.cnt", stall_cnt, 0);
    tick();
    // Mult latency
    start_E = 1; md_op_E = 2'b00;
    cyc();
    start_E = 0;
    bmask = 0; dmask = 0;
    for (int i = 1; i <= 7; i++) begin
      cmp_all();
      bmask[i-1] = busy; dmask[i-1] = md_done;
      tick();
    end
    chk("mult.busy_mask", 32'(bmask), 32'h1F);
    chk("mult.done_mask", 32'(dmask), 32'h20);
    chk("mult.kind", 32'(md_kind), 0);
    // Div with dependent mflo held in ID
    do_reset();
    start_E = 1; md_op_E = 2'b10; md_use_D = 1;
    stall_n = 0;
    for (int i = 0; i <= 11; i++) begin
      if (i == 1) start_E = 0;
      if (i == 11) md_use_D = 0;
      cmp_all();
      if (stall && !PC_EN && NOP_CLR) stall_n++;
      tick();
    end
    chk("div.stall_cycles", 32'(stall_n), 11);
    cmp_all();
    chk("div.stall_cnt", stall_cnt, 11);
    tick();
    // Start dropped by a coincident exception
    start_E = 1; md_op_E = 2'b01; exc_flush = 1;
    cmp_all();
    chk("exc.nop", 32'(NOP_CLR), 1);
    tick();
    idle_inputs();
    cmp_all();
    chk("exc.busy", 32'(busy), 0);
    tick();
    // Exception during RUN does not abort
    start_E = 1; md_op_E = 2'b11;
    cyc();
    start_E = 0;
    done_at = 0; busy_n = 0;
    for (int i = 1; i <= 13; i++) begin
      exc_flush = (i == 3);
      cmp_all();
      if (busy) busy_n++;
      if (md_done) done_at = i;
      tick();
    end
    exc_flush = 0;
    chk("excrun.busy_n", 32'(busy_n), 10);
    chk("excrun.done_at", 32'(done_at), 11);
    chk("excrun.kind", 32'(md_kind), 3);
    // Back-to-back: restart in DONE, stray start during RUN ignored
    start_E = 1; md_op_E = 2'b00;
    cyc();
    done_at = 0; done2_at = 0; busy_n = 0;
    for (int i = 1; i <= 19; i++) begin
      start_E = (i == 3 || i == 6 || i == 10);
      md_op_E = (i == 6) ? 2'b11 : 2'b00;
      cmp_all();
      if (md_done && i < 10) done_at = i;
      if (md_done && i >= 10) done2_at = i;
      if (busy && i >= 7) busy_n++;
      tick();
    end
    start_E = 0;
    chk("b2b.done1", 32'(done_at), 6);
    chk("b2b.busy2", 32'(busy_n), 10);
    chk("b2b.done2", 32'(done2_at), 17);
    chk("b2b.kind", 32'(md_kind), 3);
    // Async reset mid-div
    start_E = 1; md_op_E = 2'b10;
    cyc();
    start_E = 0;
    for (int i = 1; i < 4; i++) cyc();
    @(posedge CLK); #2;
    reset = 0;
    #1;
    chk("arst.busy", 32'(busy), 0);
    chk("arst.kind", 32'(md_kind), 0);
    chk("arst.cnt", stall_cnt, 0);
    m_reset();
    #1 reset = 1;
    done_at = 0;
    for (int i = 0; i < 12; i++) begin
      cmp_all();
      if (md_done) done_at++;
      tick();
    end
    chk("arst.no_done", 32'(done_at), 0);
    // load-use alone
    load_use_D = 1;
    cmp_all();
    chk("lu.stall", 32'(stall), 1);
    chk("lu.nop", 32'(NOP_CLR), 1);
    tick();
    load_use_D = 0;
    // Random run
    for (int i = 0; i < 2000; i++) begin
      start_E = ($urandom_range(3) == 0);
      md_op_E = 2'($urandom_range(3));
      md_use_D = $urandom_range(1) == 1;
      load_use_D = ($urandom_range(7) == 0);
      exc_flush = ($urandom_range(7) == 0);
      cyc();
    end
    idle_inputs();
    cyc();
    // Saturation of stall counter
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    mcnt = 64'hFFFF_FFFD;
    load_use_D = 1;
    for (int i = 0; i < 5; i++) cyc();
    cmp_all();
    chk("sat.cnt", stall_cnt, 32'hFFFF_FFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
